// File: rtl/router_1xn.sv
// 1-to-N byte-serial packet router: header/payload/parity framing, one
// first-word-fall-through FIFO per output channel with an unread-timeout flush.

module router_1xn_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              rd_i,
  output logic              flush_o,
  output logic              full_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] dout_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic [TW-1:0]     tmo_q;
  logic              pop, wr;

  assign valid_o = cnt_q != '0;
  assign full_o  = cnt_q == CW'(FIFO_DEPTH);
  assign flush_o = tmo_q == TW'(TIMEOUT);
  // A flush cycle swallows both the pop and any incoming byte.
  assign pop     = rd_i && valid_o && !flush_o;
  assign wr      = push_i && !flush_o && (!full_o || pop);
  assign dout_o  = valid_o ? mem[rd_q] : '0;

  always_ff @(posedge clk)
    if (wr) mem[wr_q] <= din_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
    end else if (flush_o) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
    end else begin
      if (wr)  wr_q <= wr_q + PW'(1);
      if (pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(wr) - CW'(pop);
      tmo_q <= (valid_o && !rd_i) ? tmo_q + TW'(1) : '0;
    end
  end
endmodule

module router_1xn #(
  parameter int N_PORTS    = 3,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      pkt_valid,
  output logic                      busy,
  output logic                      error,
  input  logic [N_PORTS-1:0]        read_enb,
  output logic [N_PORTS-1:0]        valid_out,
  output logic [N_PORTS*DATA_W-1:0] data_out
);
  localparam int ADDR_W = ($clog2(N_PORTS) > 1) ? $clog2(N_PORTS) : 1;
  localparam int LEN_W  = DATA_W - ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DROP} state_e;

  state_e                           state_q;
  logic [ADDR_W-1:0]                dest_q;
  logic [LEN_W:0]                   rem_q;
  logic [DATA_W-1:0]                par_q;
  logic                             error_q;
  logic [N_PORTS-1:0]               full, flush, push;
  logic [N_PORTS-1:0][DATA_W-1:0]   dout;
  logic                             accept, hdr_ok;
  logic [ADDR_W-1:0]                hdr_dest;
  logic [LEN_W-1:0]                 hdr_len;

  assign hdr_dest = data_in[ADDR_W-1:0];
  assign hdr_len  = data_in[DATA_W-1:ADDR_W];
  assign hdr_ok   = int'(hdr_dest) < N_PORTS;
  assign accept   = pkt_valid && !busy;
  assign error    = error_q;
  assign data_out = dout;

  always_comb begin
    busy = 1'b0;
    case (state_q)
      LOAD:    busy = full[dest_q];
      CHECK:   busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_comb begin
    push = '0;
    if (accept) begin
      if (state_q == IDLE && hdr_ok) push[hdr_dest] = 1'b1;
      else if (state_q == LOAD)      push[dest_q]   = 1'b1;
    end
  end

  // rem_q counts the bytes still owed after the header (payload + parity).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dest_q  <= '0;
      rem_q   <= '0;
      par_q   <= '0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          rem_q   <= {1'b0, hdr_len} + (LEN_W+1)'(1);
          par_q   <= data_in;
          dest_q  <= hdr_dest;
          error_q <= 1'b0;
          state_q <= (hdr_ok && !flush[hdr_dest]) ? LOAD : DROP;
        end
        LOAD: begin
          if (accept) begin
            par_q <= par_q ^ data_in;
            rem_q <= rem_q - (LEN_W+1)'(1);
          end
          // A flush of our channel turns the rest of the packet into a drop.
          if (flush[dest_q])
            state_q <= (accept && rem_q == (LEN_W+1)'(1)) ? IDLE : DROP;
          else if (accept && rem_q == (LEN_W+1)'(1))
            state_q <= CHECK;
        end
        CHECK: begin
          error_q <= |par_q;
          state_q <= IDLE;
        end
        DROP: if (accept) begin
          rem_q <= rem_q - (LEN_W+1)'(1);
          if (rem_q == (LEN_W+1)'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_ch
    router_1xn_fifo #(
      .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[g]),
      .din_i   (data_in),
      .rd_i    (read_enb[g]),
      .flush_o (flush[g]),
      .full_o  (full[g]),
      .valid_o (valid_out[g]),
      .dout_o  (dout[g])
    );
  end
endmodule

// File: tb/tb_router_1xn.sv
// Bench for router_1xn: directed scenarios plus randomized traffic checked
// against a queue-based packet model.

module tb_router_1xn;
  localparam int N = 3, W = 8, D = 16, TMO = 30;

  logic           clk = 1'b0, rst = 1'b0, pkt_valid = 1'b0;
  logic           busy, error;
  logic [W-1:0]   data_in = '0;
  logic [N-1:0]   read_enb = '0, valid_out;
  logic [N*W-1:0] data_out;
  int             n_chk = 0, n_fail = 0;

  router_1xn #(.N_PORTS(N), .DATA_W(W), .FIFO_DEPTH(D), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .pkt_valid(pkt_valid),
    .busy(busy), .error(error), .read_enb(read_enb),
    .valid_out(valid_out), .data_out(data_out));

  always #5 clk = ~clk;

  // Model: per-channel byte queues, idle ages, and the packet being received.
  logic [W-1:0] mq [N][$];
  int           age [N];
  int           left, mdest;
  bit           keep, chkp, merr;
  logic [W-1:0] mpar;
  logic [W-1:0] pkt [$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mq[i].delete(); age[i] = 0; end
    left = 0; mdest = 0; keep = 0; chkp = 0; merr = 0; mpar = '0;
  endtask

  function automatic bit m_busy();
    if (chkp) return 1'b1;
    if (keep && left > 0 && mq[mdest].size() == D) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick(input bit pv, input logic [W-1:0] din, input logic [N-1:0] rd);
    bit acc;
    bit fl [N];
    bit vld [N];
    pkt_valid = pv; data_in = din; read_enb = rd;
    acc = pv && !m_busy();
    for (int i = 0; i < N; i++) begin fl[i] = (age[i] == TMO); vld[i] = mq[i].size() > 0; end
    @(posedge clk);
    for (int i = 0; i < N; i++)
      if (!fl[i] && rd[i] && vld[i]) void'(mq[i].pop_front());
    if (chkp) begin
      merr = (mpar != 0); chkp = 0;
    end else if (acc && left == 0) begin
      mdest = int'(din % 4); left = int'(din / 4) + 1; mpar = din; merr = 0;
      keep = 0;
      if (mdest < N) keep = !fl[mdest];
      if (keep && mq[mdest].size() < D) mq[mdest].push_back(din);
    end else if (acc) begin
      left--; mpar ^= din;
      if (keep && fl[mdest]) keep = 0;
      if (keep) begin
        if (mq[mdest].size() < D) mq[mdest].push_back(din);
        if (left == 0) chkp = 1;
      end
    end else if (keep && left > 0 && fl[mdest]) keep = 0;
    for (int i = 0; i < N; i++)
      if (fl[i]) begin mq[i].delete(); age[i] = 0; end
      else age[i] = (vld[i] && !rd[i]) ? age[i] + 1 : 0;
    @(negedge clk);
  endtask

  task automatic make_pkt(input int dest, input int len, input bit bad);
    logic [W-1:0] p;
    pkt.delete();
    p = W'(len * 4 + dest);
    pkt.push_back(p);
    for (int k = 0; k < len; k++) begin
      pkt.push_back(W'($urandom_range(0, 255)));
      p ^= pkt[k+1];
    end
    pkt.push_back(bad ? ~p : p);
  endtask

  task automatic send_all(input logic [N-1:0] rd);
    int guard = 0;
    bit a;
    while (pkt.size() > 0 && guard < 300) begin
      a = !m_busy();
      tick(1'b1, pkt[0], rd);
      if (a) void'(pkt.pop_front());
      guard++;
    end
    n_chk++;
    if (pkt.size() != 0) begin
      n_fail++; $display("FAIL send_bound: %0d bytes unsent, expected 0", pkt.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; model_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_chk++; if (error !== 1'b0)    begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
    n_chk++; if (valid_out !== '0)  begin n_fail++; $display("FAIL reset_valid: got %b expected 000", valid_out); end
    n_chk++; if (data_out !== '0)   begin n_fail++; $display("FAIL reset_data: got %h expected 0", data_out); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] p = '0;
    logic [W-1:0] exp [$];
    pkt = {8'h15, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    foreach (pkt[k]) p ^= pkt[k];
    pkt.push_back(p);
    exp = pkt;
    foreach (exp[k]) begin
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_load[%0d]: got %b expected 0", k, busy); end
      tick(1'b1, exp[k], 3'b000);
    end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_check: got %b expected 1", busy); end
    tick(1'b0, 8'h00, 3'b000);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    n_chk++; if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b expected 0", error); end
    n_chk++; if (valid_out !== 3'b010) begin n_fail++; $display("FAIL basic_valid: got %b expected 010", valid_out); end
    foreach (exp[k]) begin
      n_chk++;
      if (valid_out !== 3'b010 || data_out[15:8] !== exp[k]) begin
        n_fail++; $display("FAIL basic_read[%0d]: got v=%b d=%h expected v=010 d=%h", k, valid_out, data_out[15:8], exp[k]);
      end
      tick(1'b0, 8'h00, 3'b010);
    end
    n_chk++; if (valid_out !== 3'b000) begin n_fail++; $display("FAIL basic_empty: got %b expected 000", valid_out); end
  endtask

  task automatic test_parity();
    logic [W-1:0] exp [$];
    pkt = {8'h15, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h11};
    exp = pkt;
    send_all(3'b000);
    tick(1'b0, 8'h00, 3'b000);
    n_chk++; if (error !== 1'b1) begin n_fail++; $display("FAIL parity_error_set: got %b expected 1", error); end
    foreach (exp[k]) begin
      n_chk++;
      if (data_out[15:8] !== exp[k]) begin n_fail++; $display("FAIL parity_read[%0d]: got %h expected %h", k, data_out[15:8], exp[k]); end
      tick(1'b0, 8'h00, 3'b010);
    end
    n_chk++; if (error !== 1'b1) begin n_fail++; $display("FAIL parity_error_hold: got %b expected 1", error); end
    make_pkt(0, 2, 1'b0);
    exp = pkt;
    tick(1'b1, pkt[0], 3'b000);
    void'(pkt.pop_front());
    n_chk++; if (error !== 1'b0) begin n_fail++; $display("FAIL parity_error_clear: got %b expected 0", error); end
    send_all(3'b000);
    tick(1'b0, 8'h00, 3'b000);
    foreach (exp[k]) begin
      n_chk++;
      if (data_out[7:0] !== exp[k]) begin n_fail++; $display("FAIL parity_next_read[%0d]: got %h expected %h", k, data_out[7:0], exp[k]); end
      tick(1'b0, 8'h00, 3'b001);
    end
    n_chk++; if (error !== 1'b0) begin n_fail++; $display("FAIL parity_next_error: got %b expected 0", error); end
  endtask

  task automatic test_full();
    logic [W-1:0] exp [$];
    make_pkt(2, 15, 1'b0);
    exp = pkt;
    for (int k = 0; k < 16; k++) begin
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_fill[%0d]: got %b expected 0", k, busy); end
      tick(1'b1, exp[k], 3'b000);
    end
    for (int s = 0; s < 2; s++) begin
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_stall[%0d]: got %b expected 1", s, busy); end
      tick(1'b1, exp[16], 3'b000);
    end
    n_chk++; if (data_out[23:16] !== exp[0]) begin n_fail++; $display("FAIL full_head: got %h expected %h", data_out[23:16], exp[0]); end
    tick(1'b1, exp[16], 3'b100);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_drop: got %b expected 0", busy); end
    tick(1'b1, exp[16], 3'b000);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_check: got %b expected 1", busy); end
    tick(1'b0, 8'h00, 3'b000);
    for (int k = 1; k < 17; k++) begin
      n_chk++;
      if (valid_out[2] !== 1'b1 || data_out[23:16] !== exp[k]) begin
        n_fail++; $display("FAIL full_read[%0d]: got v=%b d=%h expected v=1 d=%h", k, valid_out[2], data_out[23:16], exp[k]);
      end
      tick(1'b0, 8'h00, 3'b100);
    end
    n_chk++; if (valid_out !== 3'b000) begin n_fail++; $display("FAIL full_empty: got %b expected 000", valid_out); end
    n_chk++; if (error !== 1'b0) begin n_fail++; $display("FAIL full_error: got %b expected 0", error); end
  endtask

  task automatic test_timeout();
    logic [W-1:0] p0 [$], p1 [$], got [$], stream [$];
    bit pv, a;
    make_pkt(1, 3, 1'b0); p1 = pkt;
    make_pkt(0, 1, 1'b0); p0 = pkt;
    stream = {p0, p1};
    tick(1'b1, stream[0], 3'b010);
    void'(stream.pop_front());
    for (int t = 1; t <= 31; t++) begin
      if (valid_out[1]) got.push_back(data_out[15:8]);
      pv = stream.size() > 0;
      a  = pv && !m_busy();
      tick(pv, pv ? stream[0] : 8'h00, 3'b010);
      if (a) void'(stream.pop_front());
      n_chk++;
      if (valid_out[0] !== (t <= 30)) begin
        n_fail++; $display("FAIL timeout_valid0[t=%0d]: got %b expected %b", t, valid_out[0], t <= 30);
      end
    end
    n_chk++;
    if (got.size() != p1.size()) begin n_fail++; $display("FAIL timeout_ch1_len: got %0d expected %0d", got.size(), p1.size()); end
    else foreach (p1[k]) begin
      n_chk++;
      if (got[k] !== p1[k]) begin n_fail++; $display("FAIL timeout_ch1[%0d]: got %h expected %h", k, got[k], p1[k]); end
    end
  endtask

  task automatic test_drop();
    logic [W-1:0] bytes [3];
    logic [W-1:0] exp [$];
    bytes[0] = 8'h07; bytes[1] = W'($urandom_range(0, 255)); bytes[2] = W'($urandom_range(0, 255));
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy[%0d]: got %b expected 0", k, busy); end
      tick(1'b1, bytes[k], 3'b000);
      n_chk++; if (valid_out !== 3'b000) begin n_fail++; $display("FAIL drop_valid[%0d]: got %b expected 000", k, valid_out); end
      n_chk++; if (error !== 1'b0) begin n_fail++; $display("FAIL drop_error[%0d]: got %b expected 0", k, error); end
    end
    make_pkt(2, 3, 1'b0);
    exp = pkt;
    send_all(3'b000);
    tick(1'b0, 8'h00, 3'b000);
    foreach (exp[k]) begin
      n_chk++;
      if (data_out[23:16] !== exp[k]) begin n_fail++; $display("FAIL drop_next_read[%0d]: got %h expected %h", k, data_out[23:16], exp[k]); end
      tick(1'b0, 8'h00, 3'b100);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp [$];
    make_pkt(0, 4, 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b1, pkt[k], 3'b000);
    n_chk++; if (valid_out !== 3'b001) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 001", valid_out); end
    #2 rst = 1'b0; pkt_valid = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || error !== 1'b0 || valid_out !== '0 || data_out !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got busy=%b error=%b valid=%b data=%h expected all 0", busy, error, valid_out, data_out);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    make_pkt(0, 3, 1'b0);
    exp = pkt;
    send_all(3'b000);
    tick(1'b0, 8'h00, 3'b000);
    foreach (exp[k]) begin
      n_chk++;
      if (data_out[7:0] !== exp[k]) begin n_fail++; $display("FAIL rstmid_read[%0d]: got %h expected %h", k, data_out[7:0], exp[k]); end
      tick(1'b0, 8'h00, 3'b001);
    end
    n_chk++; if (valid_out !== 3'b000) begin n_fail++; $display("FAIL rstmid_empty: got %b expected 000", valid_out); end
  endtask

  task automatic test_random();
    logic [N-1:0]   rd, ev;
    logic [N*W-1:0] ed;
    int             stall = 0;
    bit             pv, a;
    pkt.delete();
    for (int c = 0; c < 600; c++) begin
      if (c % 100 == 0) stall = int'($urandom_range(0, N - 1));
      ev = '0; ed = '0;
      for (int i = 0; i < N; i++)
        if (mq[i].size() > 0) begin ev[i] = 1'b1; ed[i*W +: W] = mq[i][0]; end
      n_chk++; if (busy !== m_busy()) begin n_fail++; $display("FAIL rand_busy[c=%0d]: got %b expected %b", c, busy, m_busy()); end
      n_chk++; if (error !== merr)    begin n_fail++; $display("FAIL rand_error[c=%0d]: got %b expected %b", c, error, merr); end
      n_chk++; if (valid_out !== ev)  begin n_fail++; $display("FAIL rand_valid[c=%0d]: got %b expected %b", c, valid_out, ev); end
      n_chk++; if (data_out !== ed)   begin n_fail++; $display("FAIL rand_data[c=%0d]: got %h expected %h", c, data_out, ed); end
      if (pkt.size() == 0)
        make_pkt(int'($urandom_range(0, 3)), int'($urandom_range(1, 12)), $urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) rd[i] = (i != stall) && ($urandom_range(0, 2) != 0);
      pv = $urandom_range(0, 3) != 0;
      a  = pv && !m_busy();
      tick(pv, pv ? pkt[0] : 8'h00, rd);
      if (a) void'(pkt.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_full();
    test_timeout();
    test_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
